// File: rtl/demux12_2bit_tdm.sv
// Receive-side 1:2 time-division demultiplexer for the 2:1 2-bit mux stream.
// Words are steered to x or y by an explicit select or by a frame-sync FSM.
module demux12_2bit_tdm #(
   parameter int WIDTH   = 2,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mode,
   input  logic             s,
   input  logic             in_valid,
   input  logic             in_sync,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic             x_stb,
   output logic             y_stb,
   output logic             locked,
   output logic             sync_err
);

   typedef enum logic [1:0] {
      HUNT     = 2'd0,
      EXPECT_Y = 2'd1,
      EXPECT_X = 2'd2
   } state_t;

   localparam logic [7:0] TO_CNT = TIMEOUT[7:0];

   state_t           state, state_n;
   logic [7:0]       cnt, cnt_n, cnt_inc;
   logic [WIDTH-1:0] x_n, y_n;
   logic             x_stb_n, y_stb_n, locked_n, sync_err_n;

   assign cnt_inc = cnt + 8'd1;

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      x_n        = x;
      y_n        = y;
      x_stb_n    = 1'b0;
      y_stb_n    = 1'b0;
      locked_n   = locked;
      sync_err_n = 1'b0;

      if (!mode) begin
         // Manual routing; the frame tracker is parked so auto mode restarts clean.
         state_n  = HUNT;
         cnt_n    = 8'd0;
         locked_n = 1'b0;
         if (in_valid) begin
            if (s) begin
               x_n     = d;
               x_stb_n = 1'b1;
            end else begin
               y_n     = d;
               y_stb_n = 1'b1;
            end
         end
      end else begin
         case (state)
            HUNT: begin
               cnt_n = 8'd0;
               if (in_valid && in_sync) begin
                  x_n      = d;
                  x_stb_n  = 1'b1;
                  locked_n = 1'b1;
                  state_n  = EXPECT_Y;
               end
            end
            EXPECT_Y, EXPECT_X: begin
               if (in_valid) begin
                  cnt_n = 8'd0;
                  if (in_sync) begin
                     // A sync word in the Y slot is a resync: take it as the new X.
                     x_n        = d;
                     x_stb_n    = 1'b1;
                     sync_err_n = (state == EXPECT_Y);
                     state_n    = EXPECT_Y;
                  end else if (state == EXPECT_Y) begin
                     y_n     = d;
                     y_stb_n = 1'b1;
                     state_n = EXPECT_X;
                  end else begin
                     sync_err_n = 1'b1;
                     locked_n   = 1'b0;
                     state_n    = HUNT;
                  end
               end else if (cnt_inc == TO_CNT) begin
                  cnt_n    = 8'd0;
                  locked_n = 1'b0;
                  state_n  = HUNT;
               end else begin
                  cnt_n = cnt_inc;
               end
            end
            default: begin
               state_n  = HUNT;
               cnt_n    = 8'd0;
               locked_n = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= HUNT;
         cnt      <= 8'd0;
         x        <= '0;
         y        <= '0;
         x_stb    <= 1'b0;
         y_stb    <= 1'b0;
         locked   <= 1'b0;
         sync_err <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         x        <= x_n;
         y        <= y_n;
         x_stb    <= x_stb_n;
         y_stb    <= y_stb_n;
         locked   <= locked_n;
         sync_err <= sync_err_n;
      end
   end

endmodule

// File: tb/tb_demux12_2bit_tdm.sv
// Scoreboard bench for demux12_2bit_tdm: each driven cycle queues its expected
// outputs, and a monitor compares them one cycle later.
module tb_demux12_2bit_tdm;

   logic       clk = 1'b0;
   logic       reset, mode, s, in_valid, in_sync;
   logic [1:0] d, x, y;
   logic       x_stb, y_stb, locked, sync_err;

   typedef struct {
      int         id;
      logic [1:0] x;
      logic [1:0] y;
      logic       xs;
      logic       ys;
      logic       lk;
      logic       se;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   step_id = 0;

   demux12_2bit_tdm #(.WIDTH(2), .TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .mode(mode), .s(s), .in_valid(in_valid),
      .in_sync(in_sync), .d(d), .x(x), .y(y), .x_stb(x_stb), .y_stb(y_stb),
      .locked(locked), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs and queue what the outputs must be after the next edge.
   task automatic step(input logic rst, input logic md, input logic sel,
                       input logic v, input logic sy, input logic [1:0] dd,
                       input logic [1:0] ex, input logic [1:0] ey,
                       input logic exs, input logic eys, input logic el,
                       input logic ese);
      exp_t e;
      @(negedge clk);
      reset = rst; mode = md; s = sel; in_valid = v; in_sync = sy; d = dd;
      step_id++;
      e.id = step_id; e.x = ex; e.y = ey; e.xs = exs; e.ys = eys; e.lk = el; e.se = ese;
      exp_q.push_back(e);
   endtask

   // Monitor: every cycle the DUT presents a registered output vector.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (x !== e.x || y !== e.y || x_stb !== e.xs || y_stb !== e.ys ||
                locked !== e.lk || sync_err !== e.se) begin
               failures++;
               $display("FAIL step%0d: got x=%b y=%b xs=%b ys=%b lk=%b se=%b, want x=%b y=%b xs=%b ys=%b lk=%b se=%b",
                        e.id, x, y, x_stb, y_stb, locked, sync_err,
                        e.x, e.y, e.xs, e.ys, e.lk, e.se);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; mode = 1'b1; s = 1'b1; in_valid = 1'b1; in_sync = 1'b1; d = 2'b11;

      // reset held for 2 cycles with busy inputs
      step(1,1,1,1,1,2'b11, 2'b00,2'b00,0,0,0,0);
      step(1,1,1,1,1,2'b11, 2'b00,2'b00,0,0,0,0);

      // manual mode
      step(0,0,1,1,0,2'b10, 2'b10,2'b00,1,0,0,0);
      step(0,0,0,1,0,2'b01, 2'b10,2'b01,0,1,0,0);
      step(0,0,0,0,1,2'b11, 2'b10,2'b01,0,0,0,0);

      // auto lock
      step(0,1,0,1,0,2'b11, 2'b10,2'b01,0,0,0,0);
      step(0,1,0,1,1,2'b10, 2'b10,2'b01,1,0,1,0);
      step(0,1,0,1,0,2'b01, 2'b10,2'b01,0,1,1,0);
      step(0,1,0,1,1,2'b11, 2'b11,2'b01,1,0,1,0);

      // double sync in EXPECT_Y
      step(0,1,0,1,1,2'b01, 2'b01,2'b01,1,0,1,1);
      step(0,1,0,1,0,2'b10, 2'b01,2'b10,0,1,1,0);

      // missing sync in EXPECT_X, then relock
      step(0,1,0,1,0,2'b11, 2'b01,2'b10,0,0,0,1);
      step(0,1,0,1,1,2'b00, 2'b00,2'b10,1,0,1,0);
      step(0,1,0,1,0,2'b11, 2'b00,2'b11,0,1,1,0);

      // idle timeout from EXPECT_X; in_sync without in_valid is ignored
      for (int i = 1; i <= 15; i++)
         step(0,1,0,0,1,2'b10, 2'b00,2'b11,0,0,(i < 15),0);
      step(0,1,0,1,0,2'b10, 2'b00,2'b11,0,0,0,0);

      // relock, then reset while in EXPECT_Y
      step(0,1,0,1,1,2'b01, 2'b01,2'b11,1,0,1,0);
      step(1,1,0,1,0,2'b10, 2'b00,2'b00,0,0,0,0);
      step(0,1,0,1,0,2'b10, 2'b00,2'b00,0,0,0,0);

      // mode 1->0 drops lock, 0->1 restarts in HUNT
      step(0,1,0,1,1,2'b11, 2'b11,2'b00,1,0,1,0);
      step(0,0,0,1,0,2'b10, 2'b11,2'b10,0,1,0,0);
      step(0,1,0,1,0,2'b01, 2'b11,2'b10,0,0,0,0);

      // idle counter clears on a valid word
      step(0,1,0,1,1,2'b00, 2'b00,2'b10,1,0,1,0);
      for (int i = 0; i < 10; i++)
         step(0,1,0,0,0,2'b00, 2'b00,2'b10,0,0,1,0);
      step(0,1,0,1,0,2'b01, 2'b00,2'b01,0,1,1,0);
      for (int i = 0; i < 10; i++)
         step(0,1,0,0,0,2'b00, 2'b00,2'b01,0,0,1,0);

      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/demux12_2bit_tdm.md
Name: demux12_2bit_tdm

Overview:
- Time-division 1-to-2 demultiplexer: the receive-side counterpart of our 2:1 2-bit mux.
- A single 2-bit word stream is produced by muxing sources x and y. This block steers each word back to registered x or y outputs.
- Routing is either manual, via an explicit select, or automatic, via a frame-sync FSM that tracks X/Y alternation.
- Outputs raise a per-channel update strobe, a lock flag and a sync-error pulse.

Parameters:
- WIDTH, 2, data word width of d, x and y.
- TIMEOUT, 15, consecutive idle cycles (in_valid=0) while locked before lock is dropped. Range 1..255; the counter is 8 bits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = manual routing by s; 1 = automatic routing by the sync FSM.
- s  input  1  manual route select: 1 -> x, 0 -> y (same sense as the mux select). Ignored when mode=1.
- in_valid  input  1  d carries a word this cycle.
- in_sync  input  1  qualifies d as an X-slot word. Used only when mode=1; meaningful only with in_valid.
- d  input  WIDTH  muxed input word.
- x  output  WIDTH  last word routed to channel x; holds between updates.
- y  output  WIDTH  last word routed to channel y; holds between updates.
- x_stb  output  1  one-cycle pulse: x was updated this cycle.
- y_stb  output  1  one-cycle pulse: y was updated this cycle.
- locked  output  1  auto mode is aligned to the X/Y frame.
- sync_err  output  1  one-cycle pulse: frame alignment violation detected.

Behaviour:
- Reset is checked on every rising clk edge with reset=1 and dominates everything else, including mid-frame. After reset:
  - x=0, y=0, x_stb=0, y_stb=0, locked=0, sync_err=0.
  - FSM=HUNT, idle counter=0.
- All outputs are registered. Latency is 1 cycle: a word accepted at edge N appears on x or y, with its strobe, after edge N. At most one strobe is high per cycle.
- Manual mode (mode=0):
  - in_valid=1 and s=1: x<=d, x_stb=1.
  - in_valid=1 and s=0: y<=d, y_stb=1.
  - in_valid=0: no update, strobes 0.
  - While mode=0, the FSM is forced to HUNT, the counter to 0, locked=0 and sync_err=0. in_sync is ignored.
- Auto mode (mode=1), FSM states HUNT, EXPECT_Y, EXPECT_X:
  - HUNT:
    - in_valid and in_sync: x<=d, x_stb=1, locked<=1, go to EXPECT_Y.
    - in_valid and !in_sync: word discarded, no error, stay in HUNT.
  - EXPECT_Y:
    - in_valid and !in_sync: y<=d, y_stb=1, go to EXPECT_X.
    - in_valid and in_sync: sync_err=1, word treated as a new X (x<=d, x_stb=1), stay in EXPECT_Y, locked stays 1. This is a resync.
  - EXPECT_X:
    - in_valid and in_sync: x<=d, x_stb=1, go to EXPECT_Y.
    - in_valid and !in_sync: sync_err=1, word discarded, go to HUNT, locked<=0.
  - Idle timeout (EXPECT_X or EXPECT_Y only):
    - The counter increments on each in_valid=0 cycle and clears on any in_valid=1.
    - On the cycle the counter reaches TIMEOUT: go to HUNT, locked<=0, counter<=0. No sync_err.
    - x and y keep their values.
  - In HUNT the counter is held at 0.
- Mode switch:
  - 1->0 takes effect on the same edge; any pending lock is lost.
  - 0->1 starts in HUNT. The first word after the switch is evaluated by the auto rules.
- x and y are never cleared except by reset.
- in_sync with in_valid=0 has no effect in any state.

Test Plan:
- Reset, then any inputs with reset=1 held for 2 cycles -> x=00, y=00, all strobes, locked and sync_err 0.
- Manual mode: mode=0, s=1, d=10, in_valid=1; then s=0, d=01 -> x=10 with x_stb on cycle 1; y=01 with y_stb on cycle 2; x still 10; locked=0.
- Auto lock: mode=1, words (sync,d) = (0,11), (1,10), (0,01), (1,11) -> first word dropped; x=10, locked=1; y=01; x=11. Strobes alternate x,y,x. No sync_err.
- Double sync: locked in EXPECT_Y, then words (1,01), (0,10) -> sync_err pulse with x=01 and x_stb; next cycle y=10 with y_stb; locked stays 1.
- Missing sync: locked in EXPECT_X, then word (0,11) -> sync_err pulse, no strobe, locked=0, x and y unchanged; next word (1,00) relocks with x=00.
- Timeout and mid-frame reset: locked, in_valid=0 for 15 cycles -> locked falls after the 15th idle edge with no sync_err. Relock, then assert reset in EXPECT_Y -> all outputs 0 and FSM in HUNT on the next cycle.
